// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the MEM stage
// and a secondary (DMA) master.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } grant_e;

  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive CPU grants taken while the DMA master waits.
module dmem_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  // A limit of 0 still needs a 1-bit register.
  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign limit_hit = (cnt_q == CntW'(STARVE_LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !limit_hit) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has fixed priority, the DMA port gets a
// forced slot after STARVE_LIMIT consecutive CPU grants while it waits.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  grant_e            grant;
  logic              cpu_acc;
  logic              limit_hit;
  logic              dma_rvalid_q;
  logic [DATA_W-1:0] dma_rdata_q;

  assign cpu_acc = cpu_rd | cpu_wr;

  dmem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (dma_req && (grant == GNT_CPU)),
    .clr      ((grant == GNT_DMA) || !dma_req),
    .limit_hit(limit_hit)
  );

  // Grant is forced idle while reset is held so nothing reaches the memory.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      grant = GNT_NONE;
    end else if (dma_req && (!cpu_acc || limit_hit)) begin
      grant = GNT_DMA;
    end else if (cpu_acc) begin
      grant = GNT_CPU;
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    dma_gnt   = 1'b0;
    unique case (grant)
      GNT_CPU: begin
        mem_wr    = cpu_wr;
        mem_rd    = cpu_rd & ~cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
      end
      GNT_DMA: begin
        mem_wr    = dma_we;
        mem_rd    = ~dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_acc && (grant == GNT_DMA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      dma_rvalid_q <= (grant == GNT_DMA) && !dma_we;
      if ((grant == GNT_DMA) && !dma_we) begin
        dma_rdata_q <= mem_rdata;
      end
    end
  end

  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule
